// File: rtl/trdb_reg_mr.sv
// trdb_reg_mr: APB control/status registers, address-range channels and software dump FIFO for the trace debugger
module trdb_reg_mr #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned XLEN = 32,
  parameter int unsigned NUM_RANGES = 4,
  parameter int unsigned SW_FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output logic [31:0]                  per_rdata_o,
  output logic                         per_ready_o,
  input  logic [31:0]                  per_wdata_i,
  input  logic [APB_ADDR_WIDTH-1:0]    per_addr_i,
  input  logic                         per_we_i,
  input  logic                         per_valid_i,
  output logic                         flush_stream_o,
  input  logic                         flush_confirm_i,
  output logic                         clear_fifo_o,
  output logic                         trace_enable_o,
  output logic                         trace_activated_o,
  output logic                         trace_full_addr_o,
  output logic                         trace_implicit_ret_o,
  input  logic                         trace_req_deactivate_i,
  output logic                         apply_filters_o,
  output logic                         trace_selected_priv_o,
  output logic [1:0]                   trace_which_priv_o,
  output logic                         trace_range_event_o,
  output logic                         trace_stop_event_o,
  output logic [NUM_RANGES-1:0]        range_en_o,
  output logic [NUM_RANGES*XLEN-1:0]   trace_lower_addr_o,
  output logic [NUM_RANGES*XLEN-1:0]   trace_higher_addr_o,
  input  logic                         trace_qualified_i,
  input  logic                         trace_priv_match_i,
  input  logic [NUM_RANGES-1:0]        trace_range_match_i,
  input  logic                         trace_fifo_overflow_i,
  input  logic                         external_fifo_overflow_i,
  output logic [31:0]                  sw_word_o,
  output logic                         sw_timed_o,
  output logic                         sw_valid_o,
  input  logic                         sw_grant_i
);
  localparam int unsigned PW = $clog2(SW_FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  logic [7:0] addr;
  logic wr, rd, wr_ctrl, wr_status, wr_filter, wr_dump, wr_dumpt;
  logic [NUM_RANGES-1:0] wr_lo, wr_hi;
  logic en_q, act_q, clr_q, flush_q, full_q, impl_q;
  logic qual_q, priv_q, tovf_q, eovf_q, sovf_q;
  logic [NUM_RANGES-1:0] match_q, ren_q;
  logic [5:0] filt_q;
  logic [XLEN-1:0] lo_q [NUM_RANGES];
  logic [XLEN-1:0] hi_q [NUM_RANGES];
  logic [32:0] mem [SW_FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic empty, full, flush_fifo, pop, push, ovf_ev;
  logic [31:0] status, filter;
  logic unused_addr;

  assign addr = per_addr_i[7:0];
  assign unused_addr = ^per_addr_i[APB_ADDR_WIDTH-1:8];
  assign wr = per_valid_i & per_we_i;
  assign rd = per_valid_i & ~per_we_i;
  assign wr_ctrl = wr && addr == 8'h00;
  assign wr_status = wr && addr == 8'h04;
  assign wr_filter = wr && addr == 8'h08;
  assign wr_dump = wr && addr == 8'h0C;
  assign wr_dumpt = wr && addr == 8'h10;
  assign per_ready_o = 1'b1;

  assign empty = cnt == '0;
  assign full = cnt == CW'(SW_FIFO_DEPTH);
  assign flush_fifo = clr_q | ~en_q;
  assign pop = sw_grant_i & ~empty & ~flush_fifo;
  assign push = (wr_dump | wr_dumpt) & ~flush_fifo & (~full | pop);
  assign ovf_ev = (wr_dump | wr_dumpt) & ~flush_fifo & full & ~pop;
  assign sw_valid_o = ~empty;
  assign sw_word_o = mem[rp][31:0];
  assign sw_timed_o = mem[rp][32];

  assign flush_stream_o = flush_q;
  assign clear_fifo_o = clr_q;
  assign trace_enable_o = en_q;
  assign trace_activated_o = act_q;
  assign trace_full_addr_o = full_q;
  assign trace_implicit_ret_o = impl_q;
  assign apply_filters_o = filt_q[0];
  assign trace_selected_priv_o = filt_q[1];
  assign trace_which_priv_o = filt_q[3:2];
  assign trace_range_event_o = filt_q[4];
  assign trace_stop_event_o = filt_q[5];
  assign range_en_o = ren_q;

  for (genvar i = 0; i < NUM_RANGES; i++) begin : g_rng
    assign trace_lower_addr_o[i*XLEN +: XLEN] = lo_q[i];
    assign trace_higher_addr_o[i*XLEN +: XLEN] = hi_q[i];
  end

  // decode writes to the per-channel range registers
  always_comb begin
    wr_lo = '0;
    wr_hi = '0;
    for (int i = 0; i < NUM_RANGES; i++) begin
      wr_lo[i] = wr && addr == 8'(32 + 8 * i);
      wr_hi[i] = wr && addr == 8'(36 + 8 * i);
    end
  end

  // assemble STATUS and FILTER read images
  always_comb begin
    status = '0;
    status[5:0] = {sovf_q, eovf_q, tovf_q, |match_q, priv_q, qual_q};
    status[15:8] = 8'(cnt);
    status[16 +: NUM_RANGES] = match_q;
    filter = '0;
    filter[5:0] = filt_q;
    filter[8 +: NUM_RANGES] = ren_q;
  end

  // combinational read mux, zero outside a read access
  always_comb begin
    per_rdata_o = '0;
    if (rd) begin
      case (addr)
        8'h00: per_rdata_o = {26'b0, impl_q, full_q, flush_q, 1'b0, act_q, en_q};
        8'h04: per_rdata_o = status;
        8'h08: per_rdata_o = filter;
        default: per_rdata_o = '0;
      endcase
      for (int i = 0; i < NUM_RANGES; i++) begin
        if (addr == 8'(32 + 8 * i)) per_rdata_o = 32'(lo_q[i]);
        if (addr == 8'(36 + 8 * i)) per_rdata_o = 32'(hi_q[i]);
      end
    end
  end

  // CTRL/FILTER bits, status input sampling and sticky overflow flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q <= 1'b0;
      act_q <= 1'b0;
      clr_q <= 1'b0;
      flush_q <= 1'b0;
      full_q <= 1'b0;
      impl_q <= 1'b0;
      filt_q <= '0;
      ren_q <= '0;
      qual_q <= 1'b0;
      priv_q <= 1'b0;
      match_q <= '0;
      tovf_q <= 1'b0;
      eovf_q <= 1'b0;
      sovf_q <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_q <= per_wdata_i[0];
        full_q <= per_wdata_i[4];
        impl_q <= per_wdata_i[5];
      end
      act_q <= trace_req_deactivate_i ? 1'b0 : wr_ctrl ? per_wdata_i[1] : act_q;
      flush_q <= flush_confirm_i ? 1'b0 : wr_ctrl ? per_wdata_i[3] : flush_q;
      clr_q <= wr_ctrl & per_wdata_i[2];
      if (wr_filter) begin
        filt_q <= per_wdata_i[5:0];
        ren_q <= per_wdata_i[8 +: NUM_RANGES];
      end
      qual_q <= trace_qualified_i;
      priv_q <= trace_priv_match_i;
      match_q <= trace_range_match_i;
      tovf_q <= trace_fifo_overflow_i | (tovf_q & ~(wr_status & per_wdata_i[3]));
      eovf_q <= external_fifo_overflow_i | (eovf_q & ~(wr_status & per_wdata_i[4]));
      sovf_q <= ovf_ev | (sovf_q & ~(wr_status & per_wdata_i[5]));
    end
  end

  // address range channel registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lo_q <= '{default: '0};
      hi_q <= '{default: '0};
    end else begin
      for (int i = 0; i < NUM_RANGES; i++) begin
        if (wr_lo[i]) lo_q[i] <= XLEN'(per_wdata_i);
        if (wr_hi[i]) hi_q[i] <= XLEN'(per_wdata_i);
      end
    end
  end

  // software FIFO pointers and occupancy, emptied by clear pulse or while disabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (flush_fifo) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // software FIFO storage: word plus timed flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mem <= '{default: '0};
    else if (push) mem[wp] <= {wr_dumpt, per_wdata_i};
  end
endmodule

// File: tb/tb_trdb_reg_mr.sv
// tb_trdb_reg_mr: randomized self-checking bench for trdb_reg_mr against a queue-based model
module tb_trdb_reg_mr;
  localparam int D = 4;
  localparam int NR = 4;
  localparam int XL = 32;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic [31:0] per_rdata_o, per_wdata_i = '0;
  logic per_ready_o;
  logic [11:0] per_addr_i = '0;
  logic per_we_i = 1'b0, per_valid_i = 1'b0;
  logic flush_stream_o, flush_confirm_i = 1'b0, clear_fifo_o;
  logic trace_enable_o, trace_activated_o, trace_full_addr_o, trace_implicit_ret_o;
  logic trace_req_deactivate_i = 1'b0;
  logic apply_filters_o, trace_selected_priv_o, trace_range_event_o, trace_stop_event_o;
  logic [1:0] trace_which_priv_o;
  logic [NR-1:0] range_en_o, trace_range_match_i = '0;
  logic [NR*XL-1:0] trace_lower_addr_o, trace_higher_addr_o;
  logic trace_qualified_i = 1'b0, trace_priv_match_i = 1'b0;
  logic trace_fifo_overflow_i = 1'b0, external_fifo_overflow_i = 1'b0;
  logic [31:0] sw_word_o;
  logic sw_timed_o, sw_valid_o, sw_grant_i = 1'b0;
  int n_checks = 0, n_fail = 0;
  logic [32:0] mq[$];
  bit m_sovf = 0;

  trdb_reg_mr #(.APB_ADDR_WIDTH(12), .XLEN(XL), .NUM_RANGES(NR), .SW_FIFO_DEPTH(D)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .per_rdata_o(per_rdata_o), .per_ready_o(per_ready_o),
    .per_wdata_i(per_wdata_i), .per_addr_i(per_addr_i), .per_we_i(per_we_i), .per_valid_i(per_valid_i),
    .flush_stream_o(flush_stream_o), .flush_confirm_i(flush_confirm_i), .clear_fifo_o(clear_fifo_o),
    .trace_enable_o(trace_enable_o), .trace_activated_o(trace_activated_o),
    .trace_full_addr_o(trace_full_addr_o), .trace_implicit_ret_o(trace_implicit_ret_o),
    .trace_req_deactivate_i(trace_req_deactivate_i), .apply_filters_o(apply_filters_o),
    .trace_selected_priv_o(trace_selected_priv_o), .trace_range_event_o(trace_range_event_o),
    .trace_stop_event_o(trace_stop_event_o), .trace_which_priv_o(trace_which_priv_o),
    .range_en_o(range_en_o), .trace_lower_addr_o(trace_lower_addr_o), .trace_higher_addr_o(trace_higher_addr_o),
    .trace_qualified_i(trace_qualified_i), .trace_priv_match_i(trace_priv_match_i),
    .trace_range_match_i(trace_range_match_i), .trace_fifo_overflow_i(trace_fifo_overflow_i),
    .external_fifo_overflow_i(external_fifo_overflow_i), .sw_word_o(sw_word_o), .sw_timed_o(sw_timed_o),
    .sw_valid_o(sw_valid_o), .sw_grant_i(sw_grant_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic g);
    @(negedge clk_i);
    per_valid_i = 1'b1; per_we_i = 1'b1; per_addr_i = 12'(a); per_wdata_i = d; sw_grant_i = g;
    @(posedge clk_i); #1;
    per_valid_i = 1'b0; per_we_i = 1'b0; sw_grant_i = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk_i);
    per_valid_i = 1'b1; per_we_i = 1'b0; per_addr_i = 12'(a);
    #1 d = per_rdata_o;
    per_valid_i = 1'b0;
  endtask

  task automatic grant_cycle(input logic g);
    @(negedge clk_i); sw_grant_i = g;
    @(posedge clk_i); #1 sw_grant_i = 1'b0;
  endtask

  // reference: one clock of the enabled software FIFO
  task automatic model_cycle(input bit psh, input bit tm, input logic [31:0] w, input bit g);
    if (g && mq.size() > 0) mq.delete(0);
    if (psh) begin
      if (mq.size() < D) mq.push_back({tm, w});
      else m_sovf = 1;
    end
  endtask

  function automatic logic [31:0] exp_status();
    return (32'(mq.size()) << 8) | (32'(m_sovf) << 5);
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    logic [7:0] maps[5] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};
    foreach (maps[k]) begin
      rd(maps[k], d);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_read addr=%h got %h exp 0", maps[k], d); end
    end
    for (int i = 0; i < 2 * NR; i++) begin
      rd(8'(32 + 4 * i), d);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_range_read idx=%0d got %h exp 0", i, d); end
    end
    n_checks++;
    if ({flush_stream_o, clear_fifo_o, trace_enable_o, trace_activated_o, trace_full_addr_o, trace_implicit_ret_o,
         apply_filters_o, trace_selected_priv_o, trace_which_priv_o, trace_range_event_o, trace_stop_event_o,
         range_en_o, trace_lower_addr_o, trace_higher_addr_o, sw_word_o, sw_timed_o, sw_valid_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got nonzero exp 0");
    end
    n_checks++; if (per_ready_o !== 1'b1) begin n_fail++; $display("FAIL ready got %b exp 1", per_ready_o); end
  endtask

  task automatic test_dump();
    logic [31:0] d;
    wr(8'h00, 32'h1, 0);
    wr(8'h0C, 32'hA5A5A5A5, 0); model_cycle(1, 0, 32'hA5A5A5A5, 0);
    wr(8'h10, 32'h12345678, 0); model_cycle(1, 1, 32'h12345678, 0);
    rd(8'h04, d);
    n_checks++; if (d[15:8] !== 8'd2) begin n_fail++; $display("FAIL dump_count got %0d exp 2", d[15:8]); end
    n_checks++; if ({sw_valid_o, sw_timed_o, sw_word_o} !== {2'b10, 32'hA5A5A5A5}) begin
      n_fail++; $display("FAIL dump_head got %b %b %h exp 1 0 a5a5a5a5", sw_valid_o, sw_timed_o, sw_word_o); end
    grant_cycle(1); model_cycle(0, 0, 0, 1);
    n_checks++; if ({sw_valid_o, sw_timed_o, sw_word_o} !== {2'b11, 32'h12345678}) begin
      n_fail++; $display("FAIL dump_timed_head got %b %b %h exp 1 1 12345678", sw_valid_o, sw_timed_o, sw_word_o); end
  endtask

  task automatic fifo_reset();
    wr(8'h00, 32'h0, 0);
    wr(8'h00, 32'h1, 0);
    mq.delete();
  endtask

  task automatic test_overflow();
    logic [31:0] d, w;
    fifo_reset();
    n_checks++; if (sw_valid_o !== 1'b0) begin n_fail++; $display("FAIL disable_flush valid got %b exp 0", sw_valid_o); end
    for (int i = 0; i < 5; i++) begin
      w = $urandom; wr(8'h0C, w, 0); model_cycle(1, 0, w, 0);
    end
    rd(8'h04, d);
    n_checks++; if (d !== exp_status()) begin n_fail++; $display("FAIL overflow_status got %h exp %h", d, exp_status()); end
    wr(8'h04, 32'h20, 0); m_sovf = 0;
    rd(8'h04, d);
    n_checks++; if (d !== exp_status()) begin n_fail++; $display("FAIL overflow_w1c got %h exp %h", d, exp_status()); end
    while (mq.size() > 0) begin
      n_checks++; if ({sw_valid_o, sw_timed_o, sw_word_o} !== {1'b1, mq[0]}) begin
        n_fail++; $display("FAIL overflow_drain got %b %h exp 1 %h", sw_valid_o, {sw_timed_o, sw_word_o}, mq[0]); end
      grant_cycle(1); model_cycle(0, 0, 0, 1);
    end
    n_checks++; if (sw_valid_o !== 1'b0) begin n_fail++; $display("FAIL overflow_fifth_absent valid got %b exp 0", sw_valid_o); end
  endtask

  task automatic test_full_pop_and_clear();
    logic [31:0] d, w;
    for (int i = 0; i < D + 1; i++) begin
      w = $urandom; wr(8'h10, w, i == D); model_cycle(1, 1, w, i == D);
    end
    rd(8'h04, d);
    n_checks++; if (d !== exp_status()) begin n_fail++; $display("FAIL full_pop_push_status got %h exp %h", d, exp_status()); end
    n_checks++; if ({sw_timed_o, sw_word_o} !== mq[0]) begin n_fail++; $display("FAIL full_pop_head got %h exp %h", {sw_timed_o, sw_word_o}, mq[0]); end
    wr(8'h00, 32'h5, 0);
    n_checks++; if (clear_fifo_o !== 1'b1) begin n_fail++; $display("FAIL clear_pulse_high got %b exp 1", clear_fifo_o); end
    @(posedge clk_i); #1; mq.delete();
    n_checks++; if ({clear_fifo_o, sw_valid_o} !== 2'b00) begin n_fail++; $display("FAIL clear_pulse_end got %b%b exp 00", clear_fifo_o, sw_valid_o); end
    rd(8'h00, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL clear_ctrl_read got %h exp 1", d); end
    rd(8'h04, d);
    n_checks++; if (d !== exp_status()) begin n_fail++; $display("FAIL clear_status got %h exp %h", d, exp_status()); end
  endtask

  task automatic test_ranges();
    logic [31:0] d, f;
    logic [XL-1:0] lo[NR], hi[NR];
    for (int i = 0; i < NR; i++) begin
      lo[i] = $urandom; hi[i] = $urandom;
      wr(8'(32 + 8 * i), lo[i], 0); wr(8'(36 + 8 * i), hi[i], 0);
    end
    for (int i = 0; i < NR; i++) begin
      rd(8'(32 + 8 * i), d);
      n_checks++; if (d !== lo[i]) begin n_fail++; $display("FAIL lower_read ch%0d got %h exp %h", i, d, lo[i]); end
      rd(8'(36 + 8 * i), d);
      n_checks++; if (d !== hi[i]) begin n_fail++; $display("FAIL higher_read ch%0d got %h exp %h", i, d, hi[i]); end
      n_checks++; if ({trace_lower_addr_o[i*XL +: XL], trace_higher_addr_o[i*XL +: XL]} !== {lo[i], hi[i]}) begin
        n_fail++; $display("FAIL range_out ch%0d got %h %h exp %h %h", i, trace_lower_addr_o[i*XL +: XL], trace_higher_addr_o[i*XL +: XL], lo[i], hi[i]); end
    end
    f = $urandom;
    wr(8'h08, f, 0);
    rd(8'h08, d);
    n_checks++; if (d !== (f & 32'h0000_0F3F)) begin n_fail++; $display("FAIL filter_read got %h exp %h", d, f & 32'h0F3F); end
    n_checks++; if ({range_en_o, trace_stop_event_o, trace_range_event_o, trace_which_priv_o, trace_selected_priv_o, apply_filters_o} !== {f[11:8], f[5:0]}) begin
      n_fail++; $display("FAIL filter_out got %b exp %b", {range_en_o, trace_stop_event_o, trace_range_event_o, trace_which_priv_o, trace_selected_priv_o, apply_filters_o}, {f[11:8], f[5:0]}); end
    wr(8'h30, 32'h1000, 0); wr(8'h34, 32'h2000, 0); wr(8'h08, 32'h400, 0);
    n_checks++; if (range_en_o !== 4'b0100) begin n_fail++; $display("FAIL range_en got %b exp 0100", range_en_o); end
    n_checks++; if ({trace_lower_addr_o[2*XL +: XL], trace_higher_addr_o[2*XL +: XL]} !== {32'h1000, 32'h2000}) begin
      n_fail++; $display("FAIL range2_out got %h exp 1000 2000", trace_lower_addr_o[2*XL +: XL]); end
    wr(8'(32 + 8 * NR), 32'hDEADBEEF, 0);
    rd(8'(32 + 8 * NR), d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_range got %h exp 0", d); end
    rd(8'h14, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_14 got %h exp 0", d); end
    rd(8'h0C, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL dump_reads_zero got %h exp 0", d); end
  endtask

  task automatic test_ctrl();
    logic [31:0] d;
    wr(8'h00, 32'h39, 0);
    repeat (3) @(posedge clk_i); #1;
    n_checks++; if ({flush_stream_o, trace_full_addr_o, trace_implicit_ret_o} !== 3'b111) begin
      n_fail++; $display("FAIL flush_held got %b exp 111", {flush_stream_o, trace_full_addr_o, trace_implicit_ret_o}); end
    @(negedge clk_i); flush_confirm_i = 1'b1; @(posedge clk_i); #1 flush_confirm_i = 1'b0;
    n_checks++; if (flush_stream_o !== 1'b0) begin n_fail++; $display("FAIL flush_confirm got %b exp 0", flush_stream_o); end
    wr(8'h00, 32'h3, 0);
    n_checks++; if (trace_activated_o !== 1'b1) begin n_fail++; $display("FAIL activate got %b exp 1", trace_activated_o); end
    trace_req_deactivate_i = 1'b1; flush_confirm_i = 1'b1;
    wr(8'h00, 32'hB, 0);
    trace_req_deactivate_i = 1'b0; flush_confirm_i = 1'b0;
    n_checks++; if ({trace_activated_o, flush_stream_o, trace_enable_o} !== 3'b001) begin
      n_fail++; $display("FAIL ctrl_priority got %b exp 001", {trace_activated_o, flush_stream_o, trace_enable_o}); end
    rd(8'h00, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL ctrl_priority_read got %h exp 1", d); end
  endtask

  task automatic test_status_inputs();
    logic [31:0] d, e;
    logic [NR-1:0] m;
    for (int i = 0; i < 8; i++) begin
      m = NR'($urandom);
      @(negedge clk_i);
      trace_qualified_i = 1'($urandom); trace_priv_match_i = 1'($urandom); trace_range_match_i = m;
      e = {12'b0, m, 13'b0, (m != 0), trace_priv_match_i, trace_qualified_i};
      rd(8'h04, d);
      n_checks++; if ((d & 32'h000F_0007) !== e) begin n_fail++; $display("FAIL status_inputs got %h exp %h", d & 32'h000F_0007, e); end
    end
    @(negedge clk_i); trace_qualified_i = 0; trace_priv_match_i = 0; trace_range_match_i = '0;
  endtask

  task automatic test_sticky();
    logic [31:0] d;
    logic [1:0] ev;
    ev = 2'($urandom_range(1, 3));
    @(negedge clk_i); trace_fifo_overflow_i = ev[0]; external_fifo_overflow_i = ev[1];
    @(posedge clk_i); #1 trace_fifo_overflow_i = 0; external_fifo_overflow_i = 0;
    repeat (2) @(posedge clk_i);
    rd(8'h04, d);
    n_checks++; if (d[4:3] !== ev) begin n_fail++; $display("FAIL sticky_set got %b exp %b", d[4:3], ev); end
    trace_fifo_overflow_i = 1'b1;
    wr(8'h04, 32'h18, 0);
    trace_fifo_overflow_i = 1'b0;
    rd(8'h04, d);
    n_checks++; if (d[4:3] !== 2'b01) begin n_fail++; $display("FAIL sticky_set_wins got %b exp 01", d[4:3]); end
    wr(8'h04, 32'h18, 0);
    rd(8'h04, d);
    n_checks++; if (d[4:3] !== 2'b00) begin n_fail++; $display("FAIL sticky_clear got %b exp 00", d[4:3]); end
  endtask

  task automatic test_random_fifo();
    logic [31:0] d, w;
    int op;
    bit g;
    wr(8'h04, 32'h38, 0); m_sovf = 0;
    for (int it = 0; it < 200; it++) begin
      op = $urandom_range(0, 3); g = 1'($urandom); w = $urandom;
      if (op < 2) begin wr(op ? 8'h10 : 8'h0C, w, g); model_cycle(1, op[0], w, g); end
      else begin grant_cycle(g); model_cycle(0, 0, 0, g); end
      n_checks++; if (sw_valid_o !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand_valid it=%0d got %b exp %b", it, sw_valid_o, mq.size() != 0); end
      if (mq.size() != 0) begin
        n_checks++; if ({sw_timed_o, sw_word_o} !== mq[0]) begin n_fail++; $display("FAIL rand_head it=%0d got %h exp %h", it, {sw_timed_o, sw_word_o}, mq[0]); end
      end
      if (it % 10 == 9) begin
        rd(8'h04, d);
        n_checks++; if (d !== exp_status()) begin n_fail++; $display("FAIL rand_status it=%0d got %h exp %h", it, d, exp_status()); end
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    test_reset();
    test_dump();
    test_overflow();
    test_full_pop_and_clear();
    test_ranges();
    test_status_inputs();
    test_random_fifo();
    test_ctrl();
    test_sticky();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/trdb_reg_mr.md
Name: trdb_reg_mr

Overview:
- Second-generation memory-mapped control/status register block for the trace debugger, on the same APB peripheral port.
- Adds parametrised address-range channels with per-channel enables.
- Adds an integrated, depth-parametrised software dump FIFO with visible occupancy.
- Adds sticky write-1-to-clear overflow flags and a self-clearing clear_fifo pulse.
- Sits between the APB bridge and the trace encoder, filter and packet streamer.

Parameters:
APB_ADDR_WIDTH, 12, width of per_addr_i; only bits [7:0] are decoded.
XLEN, 32, address width of range registers.
NUM_RANGES, 4, number of address-range channels (1..8).
SW_FIFO_DEPTH, 4, software FIFO entries (power of 2, 2..128).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
per_rdata_o  out  32  APB read data
per_ready_o  out  1  tied 1
per_wdata_i  in  32  APB write data
per_addr_i  in  APB_ADDR_WIDTH  APB address
per_we_i  in  1  write strobe
per_valid_i  in  1  access valid
flush_stream_o  out  1  CTRL.flush level
flush_confirm_i  in  1  streamer flush done
clear_fifo_o  out  1  one-cycle clear pulse
trace_enable_o / trace_activated_o / trace_full_addr_o / trace_implicit_ret_o  out  1 each  CTRL bits
trace_req_deactivate_i  in  1  filter forces activated=0
apply_filters_o / trace_selected_priv_o / trace_range_event_o / trace_stop_event_o  out  1 each  FILTER bits
trace_which_priv_o  out  2  FILTER bits
range_en_o  out  NUM_RANGES  per-channel enable
trace_lower_addr_o / trace_higher_addr_o  out  NUM_RANGES*XLEN  channel i at [i*XLEN +: XLEN]
trace_qualified_i / trace_priv_match_i  in  1  status inputs
trace_range_match_i  in  NUM_RANGES  per-channel match
trace_fifo_overflow_i / external_fifo_overflow_i  in  1  overflow events
sw_word_o  out  32  FIFO head data
sw_timed_o  out  1  head word requests a timer packet
sw_valid_o  out  1  FIFO not empty
sw_grant_i  in  1  pop when sw_valid_o=1

Behaviour:
- All registers and outputs reset to 0.
- Access decode uses per_addr_i[7:0].
- Writes take effect on the next clk_i edge.
- Reads are combinational and return 0 when there is no read access.
- Unmapped addresses read 0; writes to them are ignored.
- Register map:
  - 0x00 CTRL: [0] enable, [1] activated, [2] clear_fifo, [3] flush, [4] full_addr, [5] implicit_ret.
  - 0x04 STATUS:
    - [0] qualified, [1] priv_match, [2] range_match = OR of trace_range_match_i, all registered copies of the inputs.
    - [3] trace fifo overflow, [4] external overflow, [5] sw fifo overflow; sticky, W1C.
    - [15:8] sw fifo count.
    - [16+i] range match channel i.
  - 0x08 FILTER: [0] apply, [1] trace_priv, [3:2] which_priv, [4] range_event, [5] stop_event, [8+i] range_en[i].
  - 0x0C DUMP: write pushes word with timed=0; reads 0.
  - 0x10 DUMP_WITH_TIME: write pushes word with timed=1; reads 0.
  - 0x20+8*i LOWER_i, 0x24+8*i HIGHER_i, for i<NUM_RANGES; read/write. Addresses for i>=NUM_RANGES are unmapped.
- clear_fifo:
  - Writing 1 produces clear_fifo_o high for exactly one cycle, then the bit self-clears. CTRL[2] always reads 0.
  - The same pulse empties the software FIFO.
- flush:
  - Held until flush_confirm_i.
  - Confirm in the same cycle as a write of 1: confirm wins, flush=0.
- activated:
  - trace_req_deactivate_i forces 0 and wins over a same-cycle write of 1.
- Sticky flags:
  - A bit sets when its event input (or sw overflow) is 1.
  - A STATUS write of 1 clears it.
  - Set and clear in the same cycle: set wins.
- Software FIFO:
  - Stores 33 bits per entry (word plus timed flag). Count ranges 0..SW_FIFO_DEPTH; pointers wrap modulo depth.
  - Push while full: word dropped, sw overflow flag set.
  - Push while full with a same-cycle pop: accepted, no overflow.
  - Pop while empty is ignored.
  - sw_word_o and sw_timed_o are valid only when sw_valid_o=1.
  - Contents are flushed (count=0) on the clear pulse or while enable=0. A push while enable=0 is dropped without setting overflow.
- Channel outputs are driven directly from the registers.
- The whole block runs on clk_i; there is no internal clock gating.

Test Plan:
- Reset, then read all mapped addresses -> every read returns 0x0; all outputs 0.
- Write CTRL=0x1, then DUMP 0xA5A5A5A5, then DUMP_WITH_TIME 0x12345678, with sw_grant_i=0 -> STATUS[15:8]=2, sw_word_o=0xA5A5A5A5, sw_timed_o=0. Grant one cycle -> head becomes 0x12345678 with sw_timed_o=1.
- With depth 4, push 5 words without grant -> count=4, STATUS[5]=1, fifth word absent. Write STATUS=0x20 -> STATUS[5]=0.
- Fill the FIFO, then push with sw_grant_i=1 in the same cycle -> count stays 4, no overflow. Write CTRL=0x5 -> clear_fifo_o high for exactly 1 cycle; count=0; CTRL reads 0x1.
- Write LOWER_2=0x1000 and HIGHER_2=0x2000, then FILTER bit 10 -> range_en_o=4'b0100 and trace_lower_addr_o[2*32 +: 32]=0x1000. Address 0x20+8*NUM_RANGES reads 0.
- Write CTRL=0xB with trace_req_deactivate_i and flush_confirm_i high in the same cycle -> activated=0 and flush=0; CTRL reads 0x1.
